// File: rtl/cpu_datapath.sv
// Single-bus 32-bit CPU datapath: 16 GPRs, PC/IR/MAR/MDR/HI/LO/Y/Z, I/O ports and ALU.
// Control strobes come from an external control unit; register contents are exported for debug.
module cpu_datapath #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
   input  logic                  R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
   input  logic                  IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin,
   input  logic                  Outport_in, Inport_in, IncPC,
   input  logic                  R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
   input  logic                  R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
   input  logic                  HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
   input  logic                  Mem_read,
   input  logic [DATA_WIDTH-1:0] MDR_Mem_lines,
   input  logic [DATA_WIDTH-1:0] Inport_data_in,
   input  logic [4:0]            opcode,
   output logic [DATA_WIDTH-1:0] MAR_to_chip,
   output logic [DATA_WIDTH-1:0] Outport_data_out,
   output logic [DATA_WIDTH-1:0] reg1, reg2, reg3, reg4, reg5, reg6, reg7,
   output logic [DATA_WIDTH-1:0] regMDR, PC_VALUE, HI_VALUE, LO_VALUE, IR_VALUE,
   output logic [DATA_WIDTH-1:0] BusMuxOut_out
);
   localparam int W = DATA_WIDTH;

   localparam logic [4:0] OP_AND = 5'b00001, OP_OR  = 5'b00010, OP_ADD = 5'b00011;
   localparam logic [4:0] OP_SUB = 5'b00100, OP_SHR = 5'b00101, OP_SHRA = 5'b00110;
   localparam logic [4:0] OP_SHL = 5'b00111, OP_ROR = 5'b01000, OP_ROL = 5'b01001;
   localparam logic [4:0] OP_MUL = 5'b01111, OP_DIV = 5'b10000, OP_NEG = 5'b10001;
   localparam logic [4:0] OP_NOT = 5'b10010;

   logic [15:0]  rin, rout;
   logic [W-1:0] gpr [16];
   logic [W-1:0] pc, ir, mar, mdr, hi, lo, y, inport, outport;
   logic [2*W-1:0] z, c;
   logic [W-1:0] bus, c_ext;

   assign rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
   assign rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

   function automatic logic [2*W-1:0] alu(input logic [4:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic inc);
      logic signed [W-1:0] sa, sb;
      logic [2*W-1:0]      rot, res;
      logic [4:0]          sh;
      sa  = a;
      sb  = b;
      sh  = b[4:0];
      rot = '0;
      res = '0;
      if (inc) begin
         res[W-1:0] = b + W'(1);
      end else begin
         case (op)
            OP_AND:  res[W-1:0] = a & b;
            OP_OR:   res[W-1:0] = a | b;
            OP_ADD:  res[W-1:0] = a + b;
            OP_SUB:  res[W-1:0] = a - b;
            OP_SHR:  res[W-1:0] = a >> sh;
            OP_SHRA: res[W-1:0] = sa >>> sh;
            OP_SHL:  res[W-1:0] = a << sh;
            OP_ROR: begin
               rot = {a, a} >> sh;
               res[W-1:0] = rot[W-1:0];
            end
            OP_ROL: begin
               rot = {a, a} << sh;
               res[W-1:0] = rot[2*W-1:W];
            end
            // Sign-extend both operands so the unsigned 64-bit product equals the signed one
            OP_MUL:  res = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
            OP_DIV: begin
               if (b == '0) res = {a, {W{1'b1}}};
               else         res = {W'(sa % sb), W'(sa / sb)};
            end
            OP_NEG:  res[W-1:0] = -b;
            OP_NOT:  res[W-1:0] = ~b;
            default: res = '0;
         endcase
      end
      return res;
   endfunction

   assign c_ext = {{(W-19){ir[18]}}, ir[18:0]};
   assign c     = alu(opcode, y, bus, IncPC);

   // Later assignments win, so R0 ends up with the highest priority
   always_comb begin
      bus = '0;
      if (Cout)       bus = c_ext;
      if (Inport_out) bus = inport;
      if (MDRout)     bus = mdr;
      if (PCout)      bus = pc;
      if (Zlo_out)    bus = z[W-1:0];
      if (Zhi_out)    bus = z[2*W-1:W];
      if (LOout)      bus = lo;
      if (HIout)      bus = hi;
      for (int i = 15; i >= 0; i--)
         if (rout[i]) bus = gpr[i];
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         for (int i = 0; i < 16; i++) gpr[i] <= '0;
         pc <= '0; ir <= '0; mar <= '0; mdr <= '0; hi <= '0; lo <= '0;
         y <= '0; z <= '0; inport <= '0; outport <= '0;
      end else begin
         for (int i = 0; i < 16; i++)
            if (rin[i]) gpr[i] <= bus;
         if (PCin)       pc      <= bus;
         if (IRin)       ir      <= bus;
         if (MARin)      mar     <= bus;
         if (MDRin)      mdr     <= Mem_read ? MDR_Mem_lines : bus;
         if (HIin)       hi      <= bus;
         if (LOin)       lo      <= bus;
         if (RYin)       y       <= bus;
         if (RZin)       z       <= c;
         if (Inport_in)  inport  <= Inport_data_in;
         if (Outport_in) outport <= bus;
      end
   end

   assign MAR_to_chip      = mar;
   assign Outport_data_out = outport;
   assign reg1 = gpr[1]; assign reg2 = gpr[2]; assign reg3 = gpr[3]; assign reg4 = gpr[4];
   assign reg5 = gpr[5]; assign reg6 = gpr[6]; assign reg7 = gpr[7];
   assign regMDR   = mdr;
   assign PC_VALUE = pc;
   assign HI_VALUE = hi;
   assign LO_VALUE = lo;
   assign IR_VALUE = ir;
   assign BusMuxOut_out = bus;
endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: ALU vector table plus hand-written bus/fetch/reset sequences.
module tb_cpu_datapath;
   logic        clock = 1'b0, clear = 1'b0;
   logic [15:0] rin = '0, rout = '0;
   logic        IRin = 0, PCin = 0, RYin = 0, RZin = 0, MARin = 0, MDRin = 0, HIin = 0, LOin = 0;
   logic        Outport_in = 0, Inport_in = 0, IncPC = 0;
   logic        HIout = 0, LOout = 0, Zhi_out = 0, Zlo_out = 0, PCout = 0, MDRout = 0;
   logic        Inport_out = 0, Cout = 0, Mem_read = 0;
   logic [31:0] MDR_Mem_lines = '0, Inport_data_in = '0;
   logic [4:0]  opcode = '0;
   logic [31:0] MAR_to_chip, Outport_data_out, reg1, reg2, reg3, reg4, reg5, reg6, reg7;
   logic [31:0] regMDR, PC_VALUE, HI_VALUE, LO_VALUE, IR_VALUE, BusMuxOut_out;

   int n_total = 0, n_pass = 0;

   cpu_datapath #(.DATA_WIDTH(32)) dut (
      .clock(clock), .clear(clear),
      .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]), .R4in(rin[4]), .R5in(rin[5]),
      .R6in(rin[6]), .R7in(rin[7]), .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
      .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
      .IRin(IRin), .PCin(PCin), .RYin(RYin), .RZin(RZin), .MARin(MARin), .MDRin(MDRin),
      .HIin(HIin), .LOin(LOin), .Outport_in(Outport_in), .Inport_in(Inport_in), .IncPC(IncPC),
      .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]), .R4out(rout[4]),
      .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]), .R8out(rout[8]), .R9out(rout[9]),
      .R10out(rout[10]), .R11out(rout[11]), .R12out(rout[12]), .R13out(rout[13]),
      .R14out(rout[14]), .R15out(rout[15]),
      .HIout(HIout), .LOout(LOout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out), .PCout(PCout),
      .MDRout(MDRout), .Inport_out(Inport_out), .Cout(Cout), .Mem_read(Mem_read),
      .MDR_Mem_lines(MDR_Mem_lines), .Inport_data_in(Inport_data_in), .opcode(opcode),
      .MAR_to_chip(MAR_to_chip), .Outport_data_out(Outport_data_out),
      .reg1(reg1), .reg2(reg2), .reg3(reg3), .reg4(reg4), .reg5(reg5), .reg6(reg6), .reg7(reg7),
      .regMDR(regMDR), .PC_VALUE(PC_VALUE), .HI_VALUE(HI_VALUE), .LO_VALUE(LO_VALUE),
      .IR_VALUE(IR_VALUE), .BusMuxOut_out(BusMuxOut_out)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic [4:0]  op;
      logic        inc;
      logic [31:0] a, b, hi, lo;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      rin = '0; rout = '0;
      IRin = 0; PCin = 0; RYin = 0; RZin = 0; MARin = 0; MDRin = 0; HIin = 0; LOin = 0;
      Outport_in = 0; Inport_in = 0; IncPC = 0;
      HIout = 0; LOout = 0; Zhi_out = 0; Zlo_out = 0; PCout = 0; MDRout = 0;
      Inport_out = 0; Cout = 0; Mem_read = 0; opcode = '0;
   endtask

   // Latch a value into the in-port so the next cycle can drive it with Inport_out
   task automatic stage(input logic [31:0] v);
      idle();
      Inport_data_in = v;
      Inport_in = 1;
      tick();
      idle();
      Inport_out = 1;
   endtask

   task automatic load_gpr(input int idx, input logic [31:0] v);
      stage(v);
      rin[idx] = 1'b1;
      tick();
      idle();
   endtask

   task automatic run_alu(input logic [4:0] op, input logic inc, input logic [31:0] a,
                          input logic [31:0] b);
      stage(a);
      RYin = 1;
      tick();
      stage(b);
      opcode = op;
      IncPC = inc;
      RZin = 1;
      tick();
      idle();
   endtask

   task automatic read_z(output logic [31:0] hi_v, output logic [31:0] lo_v);
      idle();
      Zlo_out = 1; #1 lo_v = BusMuxOut_out;
      idle();
      Zhi_out = 1; #1 hi_v = BusMuxOut_out;
      idle();
   endtask

   initial begin
      logic [31:0] zh, zl;

      vecs[0]  = '{"and",      5'b00001, 1'b0, 32'h14,       32'h18,       32'h0,        32'h10};
      vecs[1]  = '{"or",       5'b00010, 1'b0, 32'h14,       32'h18,       32'h0,        32'h1C};
      vecs[2]  = '{"add_wrap", 5'b00011, 1'b0, 32'hFFFFFFFF, 32'h2,        32'h0,        32'h1};
      vecs[3]  = '{"sub",      5'b00100, 1'b0, 32'h3,        32'h5,        32'h0,        32'hFFFFFFFE};
      vecs[4]  = '{"shr",      5'b00101, 1'b0, 32'h80000000, 32'h4,        32'h0,        32'h08000000};
      vecs[5]  = '{"shra",     5'b00110, 1'b0, 32'h80000000, 32'h4,        32'h0,        32'hF8000000};
      vecs[6]  = '{"shl",      5'b00111, 1'b0, 32'h1,        32'd31,       32'h0,        32'h80000000};
      vecs[7]  = '{"ror",      5'b01000, 1'b0, 32'h1,        32'h1,        32'h0,        32'h80000000};
      vecs[8]  = '{"rol",      5'b01001, 1'b0, 32'h80000000, 32'h1,        32'h0,        32'h1};
      vecs[9]  = '{"ror_b40",  5'b01000, 1'b0, 32'h12345678, 32'h21,       32'h0,        32'h091A2B3C};
      vecs[10] = '{"mul_neg",  5'b01111, 1'b0, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA};
      vecs[11] = '{"mul_big",  5'b01111, 1'b0, 32'h00010000, 32'h00010000, 32'h1,        32'h0};
      vecs[12] = '{"div",      5'b10000, 1'b0, 32'h7,        32'h2,        32'h1,        32'h3};
      vecs[13] = '{"div_neg",  5'b10000, 1'b0, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[14] = '{"div_zero", 5'b10000, 1'b0, 32'h7,        32'h0,        32'h7,        32'hFFFFFFFF};
      vecs[15] = '{"neg",      5'b10001, 1'b0, 32'h0,        32'h5,        32'h0,        32'hFFFFFFFB};
      vecs[16] = '{"not",      5'b10010, 1'b0, 32'h0,        32'h5,        32'h0,        32'hFFFFFFFA};
      vecs[17] = '{"op_00000", 5'b00000, 1'b0, 32'h5,        32'h6,        32'h0,        32'h0};
      vecs[18] = '{"op_11111", 5'b11111, 1'b0, 32'h5,        32'h6,        32'h0,        32'h0};
      vecs[19] = '{"incpc",    5'b00011, 1'b1, 32'h5,        32'h11,       32'h0,        32'h12};

      idle();
      clear = 0;
      repeat (2) @(posedge clock);
      #1 clear = 1;
      #1;
      check("rst_mar", MAR_to_chip, 32'h0);
      check("rst_pc", PC_VALUE, 32'h0);
      check("rst_ir", IR_VALUE, 32'h0);
      check("rst_mdr", regMDR, 32'h0);
      check("rst_hi", HI_VALUE, 32'h0);
      check("rst_lo", LO_VALUE, 32'h0);
      check("rst_out", Outport_data_out, 32'h0);
      check("rst_r1r7", reg1 | reg2 | reg3 | reg4 | reg5 | reg6 | reg7, 32'h0);
      check("rst_bus", BusMuxOut_out, 32'h0);
      read_z(zh, zl);
      check("rst_zhi", zh, 32'h0);
      check("rst_zlo", zl, 32'h0);

      for (int i = 0; i < 20; i++) begin
         run_alu(vecs[i].op, vecs[i].inc, vecs[i].a, vecs[i].b);
         read_z(zh, zl);
         check({vecs[i].name, "_lo"}, zl, vecs[i].lo);
         check({vecs[i].name, "_hi"}, zh, vecs[i].hi);
      end

      // Memory read into MDR, then one bus transfer into two registers
      idle();
      MDR_Mem_lines = 32'h10; Mem_read = 1; MDRin = 1;
      tick();
      idle();
      MDRout = 1; rin[2] = 1; PCin = 1;
      tick();
      idle();
      check("mdr_load", regMDR, 32'h10);
      check("mdr_to_r2", reg2, 32'h10);
      check("mdr_to_pc", PC_VALUE, 32'h10);

      // Instruction fetch
      stage(32'h11); PCin = 1; tick(); idle();
      PCout = 1; IncPC = 1; MARin = 1; RZin = 1;
      tick();
      read_z(zh, zl);
      check("fetch_mar", MAR_to_chip, 32'h11);
      check("fetch_zlo", zl, 32'h12);
      Zlo_out = 1; PCin = 1; Mem_read = 1; MDRin = 1; MDR_Mem_lines = 32'h28918000;
      tick();
      idle();
      check("fetch_pc", PC_VALUE, 32'h12);
      MDRout = 1; IRin = 1;
      tick();
      idle();
      check("fetch_ir", IR_VALUE, 32'h28918000);

      // NEG / NOT of R7 routed back through Z into R6
      load_gpr(7, 32'h5);
      check("r7_load", reg7, 32'h5);
      rout[7] = 1; opcode = 5'b10001; RZin = 1; tick(); idle();
      Zlo_out = 1; rin[6] = 1; tick(); idle();
      check("r6_neg", reg6, 32'hFFFFFFFB);
      rout[7] = 1; opcode = 5'b10010; RZin = 1; tick(); idle();
      Zlo_out = 1; rin[6] = 1; tick(); idle();
      check("r6_not", reg6, 32'hFFFFFFFA);

      // Bus priority, Cout sign extension, HI/LO and out-port
      load_gpr(2, 32'h14);
      load_gpr(3, 32'h18);
      load_gpr(0, 32'hA0);
      rout[2] = 1; rout[3] = 1; #1;
      check("prio_r2_r3", BusMuxOut_out, 32'h14);
      idle(); rout[0] = 1; PCout = 1; Zlo_out = 1; #1;
      check("prio_r0_pc", BusMuxOut_out, 32'hA0);
      idle(); #1;
      check("bus_none", BusMuxOut_out, 32'h0);
      stage(32'h12345678); IRin = 1; tick(); idle();
      Cout = 1; #1;
      check("cout_sext", BusMuxOut_out, 32'hFFFC5678);
      idle();
      rout[3] = 1; HIin = 1; Outport_in = 1; tick(); idle();
      rout[2] = 1; LOin = 1; tick(); idle();
      check("hi_load", HI_VALUE, 32'h18);
      check("lo_load", LO_VALUE, 32'h14);
      check("outport", Outport_data_out, 32'h18);
      HIout = 1; LOout = 1; #1;
      check("prio_hi_lo", BusMuxOut_out, 32'h18);
      idle();

      // Same register driven and loaded in one cycle: R3 <= R2 while R3 also drives? R2 wins the bus
      rout[2] = 1; rout[3] = 1; rin[3] = 1; tick(); idle();
      check("self_load", reg3, 32'h14);

      // Asynchronous clear in the middle of a cycle
      @(negedge clock);
      clear = 0;
      #1;
      check("async_pc", PC_VALUE, 32'h0);
      check("async_r2", reg2, 32'h0);
      check("async_mar", MAR_to_chip, 32'h0);
      check("async_ir", IR_VALUE, 32'h0);
      @(posedge clock); #1 clear = 1;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
